uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, transmit buffer entries; power of two, 2..256.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_data  input  8  byte to transmit.
REQ-006 SHALL provide port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL provide port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL provide port txd  output  1  serial line, idle high, registered.
REQ-009 SHALL provide port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL provide port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-011 SHALL accept a byte on a rising edge where in_valid && in_ready; no other condition writes the FIFO.
REQ-012 SHALL drive in_ready = !reset && (fifo_count != FIFO_DEPTH); in_valid while full SHALL be ignored without data loss or corruption of buffered bytes.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-014 IDLE with fifo_count != 0 at an edge SHALL pop the head byte and enter START; txd = 0 from that edge, i.e. one cycle after acceptance when previously empty and idle.
REQ-015 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded on every bit boundary.
REQ-016 DATA SHALL shift out 8 bits LSB first, bit index counter 0..7, then advance to PARITY or STOP.
REQ-017 STOP SHALL drive txd = 1 for one bit time; at its end, FIFO non-empty -> pop and enter START on the same edge (no idle gap); empty -> IDLE.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 busy SHALL be 1 whenever state != IDLE or fifo_count != 0, else 0.
REQ-020 in_data/in_valid changes mid-frame SHALL not affect the frame in progress (shift register loaded at pop only).

Reset
REQ-021 While reset is high at an edge: state = IDLE, txd = 1, fifo_count = 0, pointers = 0, bit/baud counters = 0, busy = 0, in_ready = 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame, return txd to 1 at that edge, and discard all buffered bytes.
REQ-023 First byte may be accepted on the first edge after reset deasserts.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: SHALL insert PARITY state after DATA sending even parity (XOR of 8 data bits) for one bit time; frame = 11 bits (8E1).
REQ-025 Macro UART_TX_PARITY_EN undefined: SHALL omit PARITY state and logic entirely; frame = 10 bits (8N1).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-026 Single byte 0xA5 pushed while idle -> txd low one cycle later; line sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 cycles; busy clears after 40 cycles (parity build: parity bit 0, 44 cycles).
REQ-027 Push 0x00,0xFF,0x55 back-to-back -> three contiguous frames, no idle cycles between stop and next start; fifo_count 1,2,... then drains to 0.
REQ-028 Push 6 bytes with in_valid held high while first frame active -> in_ready drops when fifo_count=4; only accepted bytes transmitted, in order, none duplicated.
REQ-029 Assert reset at cycle 13 of a 0x3C frame with 2 bytes queued -> txd=1, fifo_count=0, busy=0 next edge; no further frames emitted.
REQ-030 Push on same edge as pop at fifo_count=4-1 -> fifo_count stays 3; subsequent output order matches push order across pointer wrap.

Source files
------------

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1, or 8E1 when UART_TX_PARITY_EN is defined; CLKS_PER_BIT clocks per bit.
// Start bit begins one cycle after a byte enters an empty, idle FIFO; in_ready drops only while the FIFO is full.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]       state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign in_ready = !reset && (fifo_count != FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_cnt == 16'd0);
  // Pop from IDLE or on the last cycle of STOP so back-to-back frames have no idle gap.
  assign pop      = !reset && (fifo_count != '0) &&
                    ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 1'b1;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop) begin
      state      <= START;
      txd        <= 1'b0;
      baud_cnt   <= BAUD_RELOAD;
      bit_idx    <= 3'd0;
      shreg      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^mem[rd_ptr];
`endif
    end else if (state != IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt - 16'd1;
      end else begin
        baud_cnt <= BAUD_RELOAD;
        case (state)
          START: begin
            state <= DATA;
            txd   <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              txd     <= parity_bit;
`else
              state   <= STOP;
              txd     <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            txd   <= 1'b1;
          end
`endif
          STOP: begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= 16'd0;
          end
          default: begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= 16'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; a negedge line monitor decodes frames.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int BUDGET    = 2000;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] in_data  = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Line monitor: samples mid-bit, pushes {framing_error, byte} per complete frame.
  bit         mon_active = 1'b0;
  bit         mon_err    = 1'b0;
  int         mon_cnt    = 0;
  int         mon_k      = 0;
  logic [7:0] mon_byte   = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_err    = 1'b0;
        mon_byte   = 8'd0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        mon_k = mon_cnt / CPB;
        if (mon_k == 0) begin
          if (txd !== 1'b0) mon_err = 1'b1;
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = txd;
        end else if (mon_k == FRAME_BITS - 1) begin
          if (txd !== 1'b1) mon_err = 1'b1;
          rx_q.push_back({mon_err, mon_byte});
          mon_active = 1'b0;
        end else begin
          if (txd !== ^mon_byte) mon_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (txd !== 1'b1)        begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    logic [7:0]            b;
    logic [FRAME_BITS-1:0] line;
    logic [8:0]            got;
    logic [7:0]            want;
    int                    bad;
    b = 8'hA5;
`ifdef UART_TX_PARITY_EN
    line = {1'b1, ^b, b, 1'b0};
`else
    line = {1'b1, b, 1'b0};
`endif
    in_data  = b;
    in_valid = 1'b1;
    exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    checks++; if (txd !== 1'b1)        begin failures++; $display("FAIL single_txd_accept got=%b exp=1", txd); end
    checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    checks++; if (txd !== 1'b0)        begin failures++; $display("FAIL single_start got=%b exp=0", txd); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_pop got=%0d exp=0", fifo_count); end
    bad = 0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (txd !== line[c / CPB] || busy !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0)      begin failures++; $display("FAIL single_line bad_cycles=%0d exp=0", bad); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (txd !== 1'b1)  begin failures++; $display("FAIL single_idle got=%b exp=1", txd); end
    for (int i = 0; i < BUDGET && rx_q.size() < 1; i++) tick();
    checks++;
    if (rx_q.size() != 1) begin failures++; $display("FAIL single_frames got=%0d exp=1", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== {1'b0, want}) begin failures++; $display("FAIL single_byte got=%h exp=%h", got, want); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] got;
    logic [7:0] want;
    int         cyc;
    in_valid = 1'b1;
    in_data  = 8'h00; exp_q.push_back(in_data);
    tick();
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", fifo_count); end
    in_data  = 8'hFF; exp_q.push_back(in_data);
    tick();
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count2 got=%0d exp=1", fifo_count); end
    checks++; if (txd !== 1'b0)        begin failures++; $display("FAIL b2b_start got=%b exp=0", txd); end
    in_data  = 8'h55; exp_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL b2b_count3 got=%0d exp=2", fifo_count); end
    cyc = 1;
    while (busy === 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 3 * FRAME_CYC) begin failures++; $display("FAIL b2b_span got=%0d exp=%0d", cyc, 3 * FRAME_CYC); end
    checks++; if (fifo_count !== 3'd0)  begin failures++; $display("FAIL b2b_drain got=%0d exp=0", fifo_count); end
    for (int i = 0; i < BUDGET && rx_q.size() < 3; i++) tick();
    checks++;
    if (rx_q.size() != 3) begin failures++; $display("FAIL b2b_frames got=%0d exp=3", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== {1'b0, want}) begin failures++; $display("FAIL b2b_byte got=%h exp=%h", got, want); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_full();
    logic [8:0] got;
    logic [7:0] want;
    int         idx;
    int         cyc;
    int         bad;
    bit         saw_full;
    bit         accepted;
    idx      = 0;
    cyc      = 0;
    bad      = 0;
    saw_full = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h11;
    while (idx < 6 && cyc < BUDGET) begin
      if (in_ready !== (fifo_count != 3'd4)) bad++;
      if (fifo_count === 3'd4) saw_full = 1'b1;
      accepted = in_ready;
      tick();
      cyc++;
      if (accepted) begin
        exp_q.push_back(in_data);
        idx++;
        in_data = 8'((idx + 1) * 17);
      end
    end
    in_valid = 1'b0;
    checks++; if (idx != 6)         begin failures++; $display("FAIL full_accepted got=%0d exp=6", idx); end
    checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL full_reached got=%b exp=1", saw_full); end
    checks++; if (bad != 0)         begin failures++; $display("FAIL full_ready bad_cycles=%0d exp=0", bad); end
    for (int i = 0; i < BUDGET && rx_q.size() < 6; i++) tick();
    repeat (2 * FRAME_CYC) tick();
    checks++;
    if (rx_q.size() != 6) begin failures++; $display("FAIL full_frames got=%0d exp=6", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== {1'b0, want}) begin failures++; $display("FAIL full_byte got=%h exp=%h", got, want); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int bad;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_data  = 8'h81;
    tick();
    in_data  = 8'h7E;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL rmid_queued got=%0d exp=2", fifo_count); end
    repeat (11) tick();
    reset = 1'b1;
    tick();
    checks++; if (txd !== 1'b1)        begin failures++; $display("FAIL rmid_txd got=%b exp=1", txd); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL rmid_ready got=%b exp=0", in_ready); end
    reset = 1'b0;
    bad   = 0;
    for (int c = 0; c < 3 * FRAME_CYC; c++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0)         begin failures++; $display("FAIL rmid_quiet bad_cycles=%0d exp=0", bad); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rmid_frames got=%0d exp=0", rx_q.size()); end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [8:0] got;
    logic [7:0] want;
    in_valid = 1'b1;
    in_data  = 8'hA1; exp_q.push_back(in_data); tick();
    in_data  = 8'hB2; exp_q.push_back(in_data); tick();
    in_data  = 8'hC3; exp_q.push_back(in_data); tick();
    in_data  = 8'hD4; exp_q.push_back(in_data); tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL wrap_count_pre got=%0d exp=3", fifo_count); end
    repeat (FRAME_CYC - 3) tick();
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL wrap_stop got=%b exp=1", txd); end
    in_valid = 1'b1;
    in_data  = 8'hE5; exp_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL wrap_count_same got=%0d exp=3", fifo_count); end
    checks++; if (txd !== 1'b0)        begin failures++; $display("FAIL wrap_next_start got=%b exp=0", txd); end
    for (int i = 0; i < BUDGET && rx_q.size() < 5; i++) tick();
    checks++;
    if (rx_q.size() != 5) begin failures++; $display("FAIL wrap_frames got=%0d exp=5", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== {1'b0, want}) begin failures++; $display("FAIL wrap_byte got=%h exp=%h", got, want); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
